// File: rtl/fw_pkg.sv
// Shared definitions for the feature writer: FSM encoding, default geometry
// and the field layout of the output-configuration word.
package fw_pkg;

    localparam int FW_ELEM_WIDTH = 8;
    localparam int FW_PACK_RATIO = 4;

    // i_param_cfg_output layout: burst count lives in the low half-word
    localparam int CFG_BURSTS_LSB = 0;
    localparam int CFG_BURSTS_MSB = 15;
    localparam int CFG_BURSTS_W   = CFG_BURSTS_MSB - CFG_BURSTS_LSB + 1;

    localparam int FW_STATE_W = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_RDY = 3'd1;
    localparam logic [2:0] ST_REQ      = 3'd2;
    localparam logic [2:0] ST_WAIT_RSP = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

endpackage

// File: rtl/fw_out_reg.sv
// Single-entry valid/ready holding register with a last flag. A load in the
// same cycle as a handshake replaces the entry without a bubble.
module fw_out_reg
    import fw_pkg::*;
#(
    parameter int WIDTH = FW_ELEM_WIDTH * FW_PACK_RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             flush,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last
);

    // Valid/ready: a word transfers on any cycle where valid and ready are
    // both high; data, valid and last stay frozen while valid && !ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (flush) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/feature_writer.sv
// Reads gathered results one at a time, packs them into output words and
// streams them downstream. Optional response watchdog: FW_RESP_TIMEOUT_EN.
module feature_writer
    import fw_pkg::*;
#(
    parameter int ELEM_WIDTH      = FW_ELEM_WIDTH,
    parameter int PACK_RATIO      = FW_PACK_RATIO,
    parameter int READS_PER_BURST = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic [31:0]                      i_param_cfg_output,
    input  logic                             i_gather_transfer_ready,
    input  logic                             i_gather_valid,
    input  logic [ELEM_WIDTH-1:0]            i_gather_data,
    output logic                             o_read_req,
    output logic [ELEM_WIDTH*PACK_RATIO-1:0] o_m_data,
    output logic                             o_m_valid,
    input  logic                             i_m_ready,
    output logic                             o_m_last,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err,
    output logic [FW_STATE_W-1:0]            dbg_state
);

    localparam int WORD_W = ELEM_WIDTH * PACK_RATIO;
    localparam int RC_W   = $clog2(READS_PER_BURST + 1);
    localparam int EI_W   = $clog2(PACK_RATIO + 1);

    localparam logic [RC_W-1:0] LAST_READ = RC_W'(READS_PER_BURST - 1);
    localparam logic [EI_W-1:0] LAST_LANE = EI_W'(PACK_RATIO - 1);

    generate
        if (READS_PER_BURST % PACK_RATIO != 0) begin : g_bad_ratio
            $error("feature_writer: READS_PER_BURST must be a multiple of PACK_RATIO");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("feature_writer: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    logic [FW_STATE_W-1:0]   state;
    logic [CFG_BURSTS_W-1:0] n_bursts;
    logic [CFG_BURSTS_W-1:0] burst_cnt;
    logic [CFG_BURSTS_W-1:0] cfg_bursts;
    logic [RC_W-1:0]         read_cnt;
    logic [EI_W-1:0]         elem_idx;
    logic [WORD_W-1:0]       pack_q;
    logic [WORD_W-1:0]       next_word;
    logic                    done_q;

    logic start_accept;
    logic stall;
    logic gather_take;
    logic word_full;
    logic burst_end;
    logic last_burst;
    logic load;
    logic timeout;
    logic unused_cfg;

    assign cfg_bursts = i_param_cfg_output[CFG_BURSTS_MSB:CFG_BURSTS_LSB];
    assign unused_cfg = ^i_param_cfg_output[31:CFG_BURSTS_MSB+1];

    // A start landing on the o_done cycle is dropped; the caller re-issues it.
    assign start_accept = (state == ST_IDLE) && i_start && !done_q
                        && (cfg_bursts != '0);

    // The response that completes a word needs an empty (or emptying) slot.
    assign stall = (elem_idx == LAST_LANE) && o_m_valid && !i_m_ready;

    assign gather_take = (state == ST_WAIT_RSP) && i_gather_valid;
    assign word_full   = (elem_idx == LAST_LANE);
    assign burst_end   = (read_cnt == LAST_READ);
    assign last_burst  = ((burst_cnt + 16'd1) == n_bursts);
    assign load        = gather_take && word_full;

    always_comb begin
        next_word = pack_q;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (elem_idx == EI_W'(i)) begin
                next_word[i*ELEM_WIDTH +: ELEM_WIDTH] = i_gather_data;
            end
        end
    end

`ifdef FW_RESP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Counts WAIT_RSP cycles since the last response; fires on the cycle
    // that would be the TIMEOUT_CYCLES-th without one.
    assign timeout = (state == ST_WAIT_RSP) && !i_gather_valid && (wd_cnt == WD_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt <= '0;
        end else if ((state != ST_WAIT_RSP) || i_gather_valid || timeout) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (start_accept) begin
            err_q <= 1'b0;
        end
    end

    assign o_err = err_q;
`else
    assign timeout = 1'b0;
    assign o_err   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            n_bursts  <= '0;
            burst_cnt <= '0;
            read_cnt  <= '0;
            elem_idx  <= '0;
            pack_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        n_bursts  <= cfg_bursts;
                        burst_cnt <= '0;
                        read_cnt  <= '0;
                        elem_idx  <= '0;
                        pack_q    <= '0;
                        state     <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (i_gather_transfer_ready) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!stall) begin
                        state <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (gather_take) begin
                        elem_idx <= word_full ? '0 : elem_idx + EI_W'(1);
                        pack_q   <= word_full ? '0 : next_word;
                        if (!burst_end) begin
                            read_cnt <= read_cnt + RC_W'(1);
                            state    <= ST_REQ;
                        end else begin
                            read_cnt  <= '0;
                            burst_cnt <= burst_cnt + 16'd1;
                            state     <= last_burst ? ST_DRAIN : ST_WAIT_RDY;
                        end
                    end else if (timeout) begin
                        read_cnt <= '0;
                        elem_idx <= '0;
                        pack_q   <= '0;
                        state    <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (o_m_valid && i_m_ready) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fw_out_reg #(
        .WIDTH (WORD_W)
    ) u_out_reg (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (load),
        .load_data (next_word),
        .load_last (burst_end && last_burst),
        .flush     (timeout),
        .ready     (i_m_ready),
        .data      (o_m_data),
        .valid     (o_m_valid),
        .last      (o_m_last)
    );

    assign o_read_req = (state == ST_REQ) && !stall;
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = done_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_feature_writer.sv
// Directed bench for feature_writer: a gather responder with programmable
// latency, an output monitor feeding a word scoreboard, one task per scenario.
module tb_feature_writer;
    import fw_pkg::*;

    localparam int EW = 8;
    localparam int PR = 4;
    localparam int WW = EW * PR;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [31:0]   i_param_cfg_output;
    logic          i_gather_transfer_ready;
    logic          i_gather_valid;
    logic [EW-1:0] i_gather_data;
    logic          o_read_req;
    logic [WW-1:0] o_m_data;
    logic          o_m_valid;
    logic          i_m_ready;
    logic          o_m_last;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [2:0]    dbg_state;

    feature_writer dut (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_start                 (i_start),
        .i_param_cfg_output      (i_param_cfg_output),
        .i_gather_transfer_ready (i_gather_transfer_ready),
        .i_gather_valid          (i_gather_valid),
        .i_gather_data           (i_gather_data),
        .o_read_req              (o_read_req),
        .o_m_data                (o_m_data),
        .o_m_valid               (o_m_valid),
        .i_m_ready               (i_m_ready),
        .o_m_last                (o_m_last),
        .o_busy                  (o_busy),
        .o_done                  (o_done),
        .o_err                   (o_err),
        .dbg_state               (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- responder + monitor ----------------
    int            cyc      = 0;
    int            req_cnt  = 0;
    int            done_cnt = 0;
    int            hs_cyc   = 0;
    int            done_cyc = 0;
    int            resp_lat = 2;
    bit            resp_en  = 1'b1;
    int            pend     = 0;
    logic [EW-1:0] resp_q[$];
    logic [WW-1:0] got_q[$];
    logic          got_last_q[$];
    logic [WW-1:0] exp_q[$];
    logic          exp_last_q[$];

    initial begin
        i_gather_valid = 1'b0;
        i_gather_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            i_gather_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && resp_q.size() > 0) begin
                    i_gather_valid = 1'b1;
                    i_gather_data  = resp_q.pop_front();
                end
            end
            @(negedge clk);
            cyc++;
            if (o_read_req) begin
                req_cnt++;
                if (resp_en) pend = resp_lat;
            end
            if (o_m_valid && i_m_ready) begin
                got_q.push_back(o_m_data);
                got_last_q.push_back(o_m_last);
                hs_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        step(1);
        i_param_cfg_output = {16'hA5A5, n};
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    task automatic wait_req(input int target, input int budget);
        int k;
        k = 0;
        while (req_cnt < target && k < budget) begin
            settle();
            k++;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            settle();
            k++;
        end
    endtask

    task automatic clear_sb();
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        resp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        settle();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", o_busy); end
        checks++; if (o_m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", o_m_valid); end
        checks++; if (o_m_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h need 0", o_m_data); end
        checks++; if (o_read_req !== 1'b0 || o_done !== 1'b0 || o_m_last !== 1'b0)
            begin errors++; $display("FAIL reset_pulses: req=%b done=%b last=%b need 0", o_read_req, o_done, o_m_last); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b need 0", o_err); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d need %0d", dbg_state, ST_IDLE); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_single_burst();
        int r0, d0;
        logic [WW-1:0] g;
        logic gl;
        clear_sb();
        resp_lat = 2;
        resp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back(32'h44332211);
        exp_last_q.push_back(1'b1);
        i_gather_transfer_ready = 1'b1;
        i_m_ready = 1'b1;
        r0 = req_cnt;
        d0 = done_cnt;
        pulse_start(16'd1);
        wait_done(d0 + 1, 100);
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL single_done: got %0d need %0d", done_cnt - d0, 1); end
        checks++; if (req_cnt - r0 !== 4) begin errors++; $display("FAIL single_reqs: got %0d need 4", req_cnt - r0); end
        checks++; if (done_cyc !== hs_cyc + 1) begin errors++; $display("FAIL single_done_lat: got %0d need %0d", done_cyc - hs_cyc, 1); end
        checks++; if (o_busy !== 1'b0 || dbg_state !== ST_IDLE)
            begin errors++; $display("FAIL single_idle: busy=%b state=%0d need 0/%0d", o_busy, dbg_state, ST_IDLE); end
        while (exp_q.size() > 0) begin
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL single_word: got none need %h", exp_q.pop_front());
                void'(exp_last_q.pop_front());
            end else begin
                g = got_q.pop_front(); gl = got_last_q.pop_front();
                if (g !== exp_q[0] || gl !== exp_last_q[0]) begin
                    errors++; $display("FAIL single_word: got %h/%b need %h/%b", g, gl, exp_q[0], exp_last_q[0]);
                end
                void'(exp_q.pop_front()); void'(exp_last_q.pop_front());
            end
        end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL single_extra: got %0d extra words need 0", got_q.size()); end
    endtask

    task automatic test_multi_burst();
        int r0, d0;
        logic [WW-1:0] g;
        logic gl;
        clear_sb();
        resp_lat = 1;
        for (int i = 1; i <= 12; i++) resp_q.push_back(EW'(i));
        exp_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        exp_last_q = '{1'b0, 1'b0, 1'b1};
        i_gather_transfer_ready = 1'b0;
        i_m_ready = 1'b1;
        r0 = req_cnt;
        d0 = done_cnt;
        pulse_start(16'd3);
        step(10);
        settle();
        checks++; if (req_cnt - r0 !== 0 || dbg_state !== ST_WAIT_RDY)
            begin errors++; $display("FAIL multi_hold0: reqs=%0d state=%0d need 0/%0d", req_cnt - r0, dbg_state, ST_WAIT_RDY); end
        step(1); i_gather_transfer_ready = 1'b1;
        wait_req(r0 + 4, 100);
        step(1); i_gather_transfer_ready = 1'b0;
        step(10);
        settle();
        checks++; if (req_cnt - r0 !== 4) begin errors++; $display("FAIL multi_hold1: reqs=%0d need 4", req_cnt - r0); end
        step(1); i_gather_transfer_ready = 1'b1;
        wait_req(r0 + 8, 100);
        step(1); i_gather_transfer_ready = 1'b0;
        step(10);
        settle();
        checks++; if (req_cnt - r0 !== 8) begin errors++; $display("FAIL multi_hold2: reqs=%0d need 8", req_cnt - r0); end
        step(1); i_gather_transfer_ready = 1'b1;
        wait_done(d0 + 1, 100);
        checks++; if (done_cnt !== d0 + 1 || req_cnt - r0 !== 12)
            begin errors++; $display("FAIL multi_done: done=%0d reqs=%0d need 1/12", done_cnt - d0, req_cnt - r0); end
        while (exp_q.size() > 0) begin
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL multi_word: got none need %h", exp_q.pop_front());
                void'(exp_last_q.pop_front());
            end else begin
                g = got_q.pop_front(); gl = got_last_q.pop_front();
                if (g !== exp_q[0] || gl !== exp_last_q[0]) begin
                    errors++; $display("FAIL multi_word: got %h/%b need %h/%b", g, gl, exp_q[0], exp_last_q[0]);
                end
                void'(exp_q.pop_front()); void'(exp_last_q.pop_front());
            end
        end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL multi_extra: got %0d extra words need 0", got_q.size()); end
    endtask

    task automatic test_backpressure();
        int r0, d0;
        logic [WW-1:0] g;
        logic gl;
        clear_sb();
        resp_lat = 3;
        for (int i = 0; i < 8; i++) resp_q.push_back(8'hA0 + EW'(i));
        exp_q = '{32'hA3A2A1A0, 32'hA7A6A5A4};
        exp_last_q = '{1'b0, 1'b1};
        i_gather_transfer_ready = 1'b1;
        i_m_ready = 1'b0;
        r0 = req_cnt;
        d0 = done_cnt;
        pulse_start(16'd2);
        wait_req(r0 + 7, 200);
        step(20);
        settle();
        checks++; if (req_cnt - r0 !== 7) begin errors++; $display("FAIL bp_reqs: got %0d need 7", req_cnt - r0); end
        checks++; if (o_m_valid !== 1'b1 || o_m_data !== 32'hA3A2A1A0 || o_m_last !== 1'b0)
            begin errors++; $display("FAIL bp_hold: got v=%b d=%h l=%b need 1/a3a2a1a0/0", o_m_valid, o_m_data, o_m_last); end
        checks++; if (dbg_state !== ST_REQ || o_read_req !== 1'b0)
            begin errors++; $display("FAIL bp_stall: state=%0d req=%b need %0d/0", dbg_state, o_read_req, ST_REQ); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL bp_early: got %0d words need 0", got_q.size()); end
        step(1); i_m_ready = 1'b1;
        wait_done(d0 + 1, 100);
        checks++; if (done_cnt !== d0 + 1 || req_cnt - r0 !== 8)
            begin errors++; $display("FAIL bp_done: done=%0d reqs=%0d need 1/8", done_cnt - d0, req_cnt - r0); end
        while (exp_q.size() > 0) begin
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL bp_word: got none need %h", exp_q.pop_front());
                void'(exp_last_q.pop_front());
            end else begin
                g = got_q.pop_front(); gl = got_last_q.pop_front();
                if (g !== exp_q[0] || gl !== exp_last_q[0]) begin
                    errors++; $display("FAIL bp_word: got %h/%b need %h/%b", g, gl, exp_q[0], exp_last_q[0]);
                end
                void'(exp_q.pop_front()); void'(exp_last_q.pop_front());
            end
        end
    endtask

    task automatic test_ignored_start();
        int r0, d0;
        logic [WW-1:0] g;
        logic gl;
        clear_sb();
        resp_lat = 2;
        i_gather_transfer_ready = 1'b1;
        i_m_ready = 1'b1;
        r0 = req_cnt;
        d0 = done_cnt;
        pulse_start(16'd0);
        step(10);
        settle();
        checks++; if (req_cnt - r0 !== 0 || o_busy !== 1'b0 || dbg_state !== ST_IDLE)
            begin errors++; $display("FAIL zero_n: reqs=%0d busy=%b state=%0d need 0/0/%0d", req_cnt - r0, o_busy, dbg_state, ST_IDLE); end
        i_gather_transfer_ready = 1'b0;
        resp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        pulse_start(16'd1);
        pulse_start(16'd5);
        settle();
        checks++; if (dbg_state !== ST_WAIT_RDY || o_busy !== 1'b1 || req_cnt - r0 !== 0)
            begin errors++; $display("FAIL busy_start: state=%0d busy=%b reqs=%0d need %0d/1/0", dbg_state, o_busy, req_cnt - r0, ST_WAIT_RDY); end
        step(1); i_gather_transfer_ready = 1'b1;
        wait_done(d0 + 1, 100);
        checks++; if (done_cnt !== d0 + 1 || req_cnt - r0 !== 4)
            begin errors++; $display("FAIL busy_job: done=%0d reqs=%0d need 1/4", done_cnt - d0, req_cnt - r0); end
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL busy_word: got %0d words need 1", got_q.size());
        end else begin
            g = got_q.pop_front(); gl = got_last_q.pop_front();
            if (g !== 32'hC3C2C1C0 || gl !== 1'b1) begin
                errors++; $display("FAIL busy_word: got %h/%b need c3c2c1c0/1", g, gl);
            end
        end
    endtask

    task automatic test_start_on_done();
        int k, r0;
        clear_sb();
        resp_lat = 2;
        resp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        i_gather_transfer_ready = 1'b1;
        i_m_ready = 1'b1;
        pulse_start(16'd1);
        k = 0;
        settle();
        while (!(dbg_state == ST_DRAIN && o_m_valid) && k < 100) begin
            settle();
            k++;
        end
        step(1);
        i_param_cfg_output = 32'h0000_0001;
        i_start = 1'b1;
        settle();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL sod_align: done=%b need 1", o_done); end
        r0 = req_cnt;
        step(1);
        i_start = 1'b0;
        step(4);
        settle();
        checks++; if (dbg_state !== ST_IDLE || o_busy !== 1'b0 || req_cnt !== r0)
            begin errors++; $display("FAIL sod_ignored: state=%0d busy=%b reqs=%0d need %0d/0/0", dbg_state, o_busy, req_cnt - r0, ST_IDLE); end
    endtask

    task automatic test_reset_midjob();
        int r0, d0;
        logic [WW-1:0] g;
        logic gl;
        clear_sb();
        resp_lat = 2;
        resp_q = '{8'hE0, 8'hE1};
        i_gather_transfer_ready = 1'b1;
        i_m_ready = 1'b1;
        r0 = req_cnt;
        d0 = done_cnt;
        pulse_start(16'd1);
        wait_req(r0 + 3, 100);
        step(2);
        #2;
        checks++; if (dbg_state !== ST_WAIT_RSP) begin errors++; $display("FAIL rst_pre: state=%0d need %0d", dbg_state, ST_WAIT_RSP); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0 || dbg_state !== ST_IDLE || o_read_req !== 1'b0 || o_m_valid !== 1'b0 || o_done !== 1'b0)
            begin errors++; $display("FAIL rst_async: busy=%b state=%0d req=%b valid=%b done=%b need 0", o_busy, dbg_state, o_read_req, o_m_valid, o_done); end
        step(3);
        rst_n = 1'b1;
        resp_q.delete();
        resp_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        pulse_start(16'd1);
        wait_done(d0 + 1, 100);
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL rst_done: got %0d need 1", done_cnt - d0); end
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL rst_word: got %0d words need 1", got_q.size());
        end else begin
            g = got_q.pop_front(); gl = got_last_q.pop_front();
            if (g !== 32'hD3D2D1D0 || gl !== 1'b1) begin
                errors++; $display("FAIL rst_word: got %h/%b need d3d2d1d0/1", g, gl);
            end
        end
    endtask

`ifdef FW_RESP_TIMEOUT_EN
    task automatic test_timeout();
        int r0, d0, k;
        clear_sb();
        resp_lat = 2;
        i_gather_transfer_ready = 1'b1;
        i_m_ready = 1'b1;
        r0 = req_cnt;
        d0 = done_cnt;
        pulse_start(16'd1);
        wait_req(r0 + 1, 50);
        k = 0;
        while (o_err !== 1'b1 && k < 200) begin
            settle();
            k++;
        end
        checks++; if (k !== 65) begin errors++; $display("FAIL to_cycles: err after %0d cycles need 65", k); end
        checks++; if (dbg_state !== ST_IDLE || o_m_valid !== 1'b0 || done_cnt !== d0)
            begin errors++; $display("FAIL to_abort: state=%0d valid=%b done=%0d need %0d/0/0", dbg_state, o_m_valid, done_cnt - d0, ST_IDLE); end
        resp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        pulse_start(16'd1);
        settle();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL to_clear: err=%b need 0", o_err); end
        wait_done(d0 + 1, 100);
        checks++; if (got_q.size() !== 1 || got_q[0] !== 32'hB3B2B1B0)
            begin errors++; $display("FAIL to_next: words=%0d need 1 of b3b2b1b0", got_q.size()); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b0;
        i_start = 1'b0;
        i_param_cfg_output = '0;
        i_gather_transfer_ready = 1'b0;
        i_m_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_backpressure();
        test_ignored_start();
        test_start_on_done();
        test_reset_midjob();
`ifdef FW_RESP_TIMEOUT_EN
        test_timeout();
`endif
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/feature_writer.md
Name: feature_writer

Overview:
- Read-side consumer of the gather stage. Issues single-cycle read requests into the gather SRAM and collects the returned ELEM_WIDTH results.
- Packs PACK_RATIO results into one output word. Lane 0 sits in the LSBs.
- Streams the packed words downstream over a valid/ready interface.
- Sits between the gather stage and the output DMA/writeback path. Its o_read_req drives the gather stage's feature-writer-finish input.

Parameters:
- ELEM_WIDTH, 8, width of one gathered result (gather DATA_WIDTH/4).
- PACK_RATIO, 4, results per output word.
- READS_PER_BURST, 4, reads per gather transfer. Must be a multiple of PACK_RATIO; violation is an elaboration error.
- TIMEOUT_CYCLES, 64, response watchdog limit. Used only with FW_RESP_TIMEOUT_EN.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_start, in, 1, pulse that starts a job. Ignored while o_busy=1.
- i_param_cfg_output, in, 32. Bits [15:0] = number of bursts N. N=0 means i_start is ignored.
- i_gather_transfer_ready, in, 1, gather stage holds data.
- i_gather_valid, in, 1, qualifies i_gather_data.
- i_gather_data, in, ELEM_WIDTH, returned result.
- o_read_req, out, 1, one-cycle read request pulse.
- o_m_data, out, ELEM_WIDTH*PACK_RATIO, packed word.
- o_m_valid, out, 1, output valid.
- i_m_ready, in, 1, downstream ready.
- o_m_last, out, 1, marks the final word of the job.
- o_busy, out, 1, high in any state other than IDLE.
- o_done, out, 1, one-cycle job-complete pulse.
- o_err, out, 1, sticky timeout flag. Tied 0 when the optional feature is absent.

Behaviour:
- Reset: all outputs 0. FSM=IDLE. All counters and the pack register cleared. Reset mid-job aborts immediately; no o_done is issued.
- FSM states: IDLE, WAIT_RDY, REQ, WAIT_RSP, DRAIN.
- IDLE:
  - On i_start with N!=0: latch N, clear burst_cnt, read_cnt and elem_idx, go to WAIT_RDY.
- WAIT_RDY:
  - When i_gather_transfer_ready=1, go to REQ.
- REQ:
  - Assert o_read_req for exactly one cycle, then go to WAIT_RSP.
  - Stall rule: if elem_idx==PACK_RATIO-1 and the output register holds an unaccepted word (o_m_valid=1 and i_m_ready=0), hold in REQ with o_read_req=0.
- WAIT_RSP:
  - On i_gather_valid: write i_gather_data into lane elem_idx, then increment elem_idx and read_cnt.
  - When the lane count reaches PACK_RATIO: load the word into the output register, set o_m_valid, wrap elem_idx to 0.
  - If read_cnt < READS_PER_BURST, go to REQ.
  - Otherwise: increment burst_cnt and clear read_cnt. If burst_cnt==N, go to DRAIN; else go to WAIT_RDY.
  - Request-to-response latency: nominally 2 cycles. Any latency of 1 cycle or more must work.
- i_gather_valid outside WAIT_RSP is ignored.
- Output register:
  - Single entry. o_m_data, o_m_valid and o_m_last are held stable until i_m_ready.
  - A new load in the same cycle as a handshake is legal and replaces the entry with no bubble.
- o_m_last = 1 only on the final word of the final burst.
- DRAIN:
  - On handshake of the last word: pulse o_done, go to IDLE, o_busy falls the next cycle.
- A simultaneous i_start and o_done cycle does not start a new job. i_start must be re-issued.
- Counter widths: burst_cnt is 16 bits. read_cnt and elem_idx are $clog2 of their limit+1. No wrap occurs within a legal job.

Optional Feature:
- Macro: FW_RESP_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in WAIT_RSP and resets on each i_gather_valid.
  - If it reaches TIMEOUT_CYCLES: set o_err (sticky), discard the partial pack and any unsent output word, go to IDLE, no o_done.
  - o_err clears on the next accepted i_start.
- Undefined:
  - No watchdog logic. WAIT_RSP waits indefinitely. o_err is constant 0.

Decomposition:
- Shared package/header fw_pkg holds:
  - FSM state encoding.
  - ELEM_WIDTH and PACK_RATIO defaults.
  - Field positions of i_param_cfg_output (burst count [15:0]).
- One sub-module: fw_out_reg, the single-entry valid/ready holding register with last-flag, instantiated once.

Test Plan:
- N=1, results 0x11,0x22,0x33,0x44 at 2-cycle latency, i_m_ready=1:
  - 4 o_read_req pulses.
  - One word 0x44332211 with o_m_last=1.
  - o_done one cycle after the handshake.
- N=3, i_gather_transfer_ready toggled between bursts:
  - 3 words, o_m_last only on the third.
  - No request issued while ready=0.
- i_m_ready held 0 for 20 cycles, N=2:
  - First word held stable.
  - Fourth request of burst 2 withheld until the handshake.
  - No data lost.
- i_start with cfg N=0, and i_start during busy:
  - No o_read_req and no state change in either case.
- Reset asserted during WAIT_RSP:
  - All outputs 0 asynchronously.
  - A subsequent normal job completes correctly.
- FW_RESP_TIMEOUT_EN with TIMEOUT_CYCLES=64, no response after a request:
  - o_err=1 at cycle 64, FSM in IDLE, no o_done.
  - Next i_start clears o_err.
